// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch/memory stages, the byte-bus arbiter and the RAM/IO pins.
// The arbiter uses the slave modport; the driving environment uses master.
interface mem_arbiter_if;
  logic        rdy;
  logic        d_r_req;
  logic        d_w_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_len;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_abort;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        if_ok;
  logic [31:0] if_inst;
  logic [31:0] if_inst_pc;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        busy;

  modport slave (
    input  rdy, d_r_req, d_w_req, d_addr, d_wdata, d_len,
           if_req, if_pc, if_abort, io_buffer_full, mem_din,
    output d_done, d_rdata, if_ok, if_inst, if_inst_pc,
           mem_dout, mem_a, mem_wr, busy
  );

  modport master (
    output rdy, d_r_req, d_w_req, d_addr, d_wdata, d_len,
           if_req, if_pc, if_abort, io_buffer_full, mem_din,
    input  d_done, d_rdata, if_ok, if_inst, if_inst_pc,
           mem_dout, mem_a, mem_wr, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the byte-wide RAM/IO bus: splits fetch and data accesses into
// byte transfers, absorbs the one-cycle read latency and throttles IO writes on UART full.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | bus idle, arbitrating (data write > data read > fetch)
// S_IF_RD   | instruction fetch, 4 byte reads, abortable
// S_D_RD    | data load, 1/2/4 byte reads
// S_D_WR    | data store, one byte written this cycle
// S_IO_WAIT | IO store gap/hold: mem_wr low until the UART buffer has room
module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_RD,
    S_D_RD,
    S_D_WR,
    S_IO_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic        io_q, io_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        wr_q, wr_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_inst_pc_q, if_inst_pc_d;
  logic        d_done_q, d_done_d;
  logic        if_ok_q, if_ok_d;

  logic [31:0] rd_word;
  logic [2:0]  cnt_inc;
  logic        req_io;

  // d_len=10 is not a legal size; it is treated as a word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign cnt_inc = cnt_q + 3'd1;
  assign req_io  = (bus.d_addr[17:16] == IO_HI);

  // mem_din carries the byte addressed one cycle earlier, i.e. byte cnt_q-1.
  always_comb begin
    rd_word = buf_q;
    case (cnt_q)
      3'd1:    rd_word[7:0]   = bus.mem_din;
      3'd2:    rd_word[15:8]  = bus.mem_din;
      3'd3:    rd_word[23:16] = bus.mem_din;
      3'd4:    rd_word[31:24] = bus.mem_din;
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    io_d         = io_q;
    pc_d         = pc_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    wr_d         = 1'b0;
    d_rdata_d    = d_rdata_q;
    if_inst_d    = if_inst_q;
    if_inst_pc_d = if_inst_pc_q;
    d_done_d     = 1'b0;
    if_ok_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A request still high during its own done cycle must not be reissued.
        if (!d_done_q && !if_ok_q) begin
          if (bus.d_w_req) begin
            n_d     = len_to_n(bus.d_len);
            io_d    = req_io;
            wdata_d = bus.d_wdata;
            mem_a_d = bus.d_addr;
            cnt_d   = 3'd0;
            if (req_io && bus.io_buffer_full) begin
              state_d = S_IO_WAIT;
            end else begin
              state_d    = S_D_WR;
              wr_d       = 1'b1;
              mem_dout_d = bus.d_wdata[7:0];
            end
          end else if (bus.d_r_req) begin
            n_d     = len_to_n(bus.d_len);
            io_d    = 1'b0;
            mem_a_d = bus.d_addr;
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            state_d = S_D_RD;
          end else if (bus.if_req && !bus.if_abort) begin
            n_d     = 3'd4;
            io_d    = 1'b0;
            mem_a_d = bus.if_pc;
            pc_d    = bus.if_pc;
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            state_d = S_IF_RD;
          end
        end
      end

      S_IF_RD, S_D_RD: begin
        if (state_q == S_IF_RD && bus.if_abort) begin
          state_d = S_IDLE;
        end else begin
          if (cnt_q != 3'd0) buf_d = rd_word;
          if (cnt_q == n_q) begin
            state_d = S_IDLE;
            if (state_q == S_IF_RD) begin
              if_ok_d      = 1'b1;
              if_inst_d    = rd_word;
              if_inst_pc_d = pc_q;
            end else begin
              d_done_d  = 1'b1;
              d_rdata_d = rd_word;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc != n_q) mem_a_d = mem_a_q + 32'd1;
          end
        end
      end

      S_D_WR: begin
        if (cnt_inc == n_q) begin
          state_d  = S_IDLE;
          d_done_d = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
          mem_a_d = mem_a_q + 32'd1;
          // IO bytes are separated by a gap so the full flag can catch up.
          if (io_q) begin
            state_d = S_IO_WAIT;
          end else begin
            wr_d       = 1'b1;
            mem_dout_d = byte_of(wdata_q, cnt_inc[1:0]);
          end
        end
      end

      S_IO_WAIT: begin
        if (!bus.io_buffer_full) begin
          state_d    = S_D_WR;
          wr_d       = 1'b1;
          mem_dout_d = byte_of(wdata_q, cnt_q[1:0]);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      n_q          <= 3'd0;
      io_q         <= 1'b0;
      pc_q         <= 32'd0;
      wdata_q      <= 32'd0;
      buf_q        <= 32'd0;
      mem_a_q      <= 32'd0;
      mem_dout_q   <= 8'd0;
      wr_q         <= 1'b0;
      d_rdata_q    <= 32'd0;
      if_inst_q    <= 32'd0;
      if_inst_pc_q <= 32'd0;
      d_done_q     <= 1'b0;
      if_ok_q      <= 1'b0;
    end else if (bus.rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      io_q         <= io_d;
      pc_q         <= pc_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      wr_q         <= wr_d;
      d_rdata_q    <= d_rdata_d;
      if_inst_q    <= if_inst_d;
      if_inst_pc_q <= if_inst_pc_d;
      d_done_q     <= d_done_d;
      if_ok_q      <= if_ok_d;
    end
  end

  assign bus.d_done     = d_done_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.if_ok      = if_ok_q;
  assign bus.if_inst    = if_inst_q;
  assign bus.if_inst_pc = if_inst_pc_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  // Gating with rdy keeps a paused write from landing twice.
  assign bus.mem_wr     = wr_q & bus.rdy;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus writes, read addresses and completions
// are queued when a request is driven and checked as the arbiter produces them.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   c0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic finished = 1'b0;

  mem_arbiter_if arb_if ();

  mem_arbiter #(.IO_HI(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
    logic        rd;
  } exp_t;

  exp_t exp_d[$];
  exp_t exp_if[$];
  exp_t exp_wr[$];
  exp_t exp_ra[$];

  logic [7:0] ram [int unsigned];
  logic prev_full = 1'b0;
  logic prev_io_wr = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic void push(ref exp_t q[$], input logic [31:0] a, input logic [31:0] d,
                               input int c, input logic rd);
    exp_t e;
    e.a = a; e.d = d; e.cyc = c; e.rd = rd;
    q.push_back(e);
  endfunction

  // Synchronous RAM: one cycle read latency, stalls with the rest of the system.
  always @(posedge clk) if (arb_if.rdy) arb_if.mem_din <= ram_byte(arb_if.mem_a);

  always @(negedge clk) begin
    exp_t e;
    if (arb_if.d_done) begin
      check_eq("d_done_expected", 64'(exp_d.size() > 0), 64'd1);
      if (exp_d.size() > 0) begin
        e = exp_d.pop_front();
        check_eq("d_done_cycle", 64'(cyc), 64'(e.cyc));
        if (e.rd) check_eq("d_rdata", 64'(arb_if.d_rdata), 64'(e.d));
      end
    end
    if (arb_if.if_ok) begin
      check_eq("if_ok_expected", 64'(exp_if.size() > 0), 64'd1);
      if (exp_if.size() > 0) begin
        e = exp_if.pop_front();
        check_eq("if_ok_cycle", 64'(cyc), 64'(e.cyc));
        check_eq("if_inst", 64'(arb_if.if_inst), 64'(e.d));
        check_eq("if_inst_pc", 64'(arb_if.if_inst_pc), 64'(e.a));
      end
    end
    if (arb_if.mem_wr) begin
      check_eq("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        check_eq("wr_cycle", 64'(cyc), 64'(e.cyc));
        check_eq("wr_addr", 64'(arb_if.mem_a), 64'(e.a));
        check_eq("wr_byte", 64'(arb_if.mem_dout), 64'(e.d[7:0]));
      end
      if (arb_if.mem_a[17:16] == 2'b11)
        check_eq("io_full_or_gap", 64'({prev_full, prev_io_wr}), 64'd0);
    end
    if (exp_ra.size() > 0 && exp_ra[0].cyc == cyc) begin
      e = exp_ra.pop_front();
      check_eq("rd_addr", 64'(arb_if.mem_a), 64'(e.a));
    end
    prev_full  = arb_if.io_buffer_full;
    prev_io_wr = arb_if.mem_wr && (arb_if.mem_a[17:16] == 2'b11);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until the arbiter is idle with every request retired; drops a request the
  // cycle after its completion pulse, and applies UART-full / pause windows.
  task automatic drain(input int max_cyc, input int full_cyc, input int pause_at, input int pause_len);
    logic dd, io, fin;
    fin = 1'b0;
    for (int k = 1; k <= max_cyc && !fin; k++) begin
      @(negedge clk);
      dd = arb_if.d_done;
      io = arb_if.if_ok;
      tick();
      if (dd) begin
        arb_if.d_r_req = 1'b0;
        arb_if.d_w_req = 1'b0;
      end
      if (io) arb_if.if_req = 1'b0;
      arb_if.io_buffer_full = (k < full_cyc);
      arb_if.rdy = !(k >= pause_at && k < pause_at + pause_len);
      fin = !arb_if.d_r_req && !arb_if.d_w_req && !arb_if.if_req && !arb_if.busy &&
            !arb_if.d_done && !arb_if.if_ok;
    end
    check_eq("drain_finished", 64'(fin), 64'd1);
  endtask

  task automatic check_zero_outs();
    check_eq("rst_d_done", 64'(arb_if.d_done), 64'd0);
    check_eq("rst_if_ok", 64'(arb_if.if_ok), 64'd0);
    check_eq("rst_d_rdata", 64'(arb_if.d_rdata), 64'd0);
    check_eq("rst_if_inst", 64'(arb_if.if_inst), 64'd0);
    check_eq("rst_if_inst_pc", 64'(arb_if.if_inst_pc), 64'd0);
    check_eq("rst_mem_a", 64'(arb_if.mem_a), 64'd0);
    check_eq("rst_mem_dout", 64'(arb_if.mem_dout), 64'd0);
    check_eq("rst_mem_wr", 64'(arb_if.mem_wr), 64'd0);
    check_eq("rst_busy", 64'(arb_if.busy), 64'd0);
  endtask

  initial begin
    #200000;
    check_eq("watchdog", 64'(finished), 64'd1);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    arb_if.rdy = 1'b1;
    arb_if.d_r_req = 1'b0;
    arb_if.d_w_req = 1'b0;
    arb_if.d_addr = 32'd0;
    arb_if.d_wdata = 32'd0;
    arb_if.d_len = 2'b00;
    arb_if.if_req = 1'b0;
    arb_if.if_pc = 32'd0;
    arb_if.if_abort = 1'b0;
    arb_if.io_buffer_full = 1'b0;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h204] = 8'h34; ram[32'h205] = 8'h12;
    ram[32'h200] = 8'h93; ram[32'h201] = 8'h00; ram[32'h202] = 8'h10; ram[32'h203] = 8'h00;

    repeat (2) tick();
    check_zero_outs();
    rst = 1'b0;
    repeat (2) tick();

    // Word fetch: addresses in cycles 1-4, if_ok in cycle 6.
    c0 = cyc;
    arb_if.if_pc = 32'h100;
    arb_if.if_req = 1'b1;
    for (int k = 0; k < 4; k++) push(exp_ra, 32'h100 + k, 32'd0, c0 + 1 + k, 1'b1);
    push(exp_if, 32'h100, 32'h0000_0513, c0 + 6, 1'b1);
    drain(40, 0, 0, 0);

    // Data load and fetch together: data first, fetch after the done cycle.
    c0 = cyc;
    arb_if.d_addr = 32'h204;
    arb_if.d_len = 2'b01;
    arb_if.d_r_req = 1'b1;
    arb_if.if_pc = 32'h100;
    arb_if.if_req = 1'b1;
    push(exp_ra, 32'h204, 32'd0, c0 + 1, 1'b1);
    push(exp_ra, 32'h205, 32'd0, c0 + 2, 1'b1);
    push(exp_d, 32'h204, 32'h0000_1234, c0 + 4, 1'b1);
    for (int k = 0; k < 4; k++) push(exp_ra, 32'h100 + k, 32'd0, c0 + 6 + k, 1'b1);
    push(exp_if, 32'h100, 32'h0000_0513, c0 + 11, 1'b1);
    drain(40, 0, 0, 0);

    // Word store; the request stays high through the done cycle.
    c0 = cyc;
    arb_if.d_addr = 32'h400;
    arb_if.d_wdata = 32'hDEAD_BEEF;
    arb_if.d_len = 2'b11;
    arb_if.d_w_req = 1'b1;
    push(exp_wr, 32'h400, 32'hEF, c0 + 1, 1'b0);
    push(exp_wr, 32'h401, 32'hBE, c0 + 2, 1'b0);
    push(exp_wr, 32'h402, 32'hAD, c0 + 3, 1'b0);
    push(exp_wr, 32'h403, 32'hDE, c0 + 4, 1'b0);
    push(exp_d, 32'h400, 32'd0, c0 + 5, 1'b0);
    drain(40, 0, 0, 0);

    // IO byte store with the UART full in cycles 0-2.
    c0 = cyc;
    arb_if.d_addr = 32'h0003_0000;
    arb_if.d_wdata = 32'h0000_005A;
    arb_if.d_len = 2'b00;
    arb_if.d_w_req = 1'b1;
    arb_if.io_buffer_full = 1'b1;
    push(exp_wr, 32'h0003_0000, 32'h5A, c0 + 4, 1'b0);
    push(exp_d, 32'h0003_0000, 32'd0, c0 + 5, 1'b0);
    drain(40, 3, 0, 0);

    // IO half store: one idle cycle between the two bytes.
    c0 = cyc;
    arb_if.d_addr = 32'h0003_0010;
    arb_if.d_wdata = 32'h0000_A5C3;
    arb_if.d_len = 2'b01;
    arb_if.d_w_req = 1'b1;
    push(exp_wr, 32'h0003_0010, 32'hC3, c0 + 1, 1'b0);
    push(exp_wr, 32'h0003_0011, 32'hA5, c0 + 3, 1'b0);
    push(exp_d, 32'h0003_0010, 32'd0, c0 + 4, 1'b0);
    drain(40, 0, 0, 0);

    // Fetch aborted in cycle 3, abort blocking acceptance in IDLE, then a clean fetch.
    arb_if.if_pc = 32'h300;
    arb_if.if_req = 1'b1;
    repeat (3) tick();
    arb_if.if_abort = 1'b1;
    arb_if.if_req = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 64'(arb_if.busy), 64'd1);
    tick();
    arb_if.if_abort = 1'b0;
    @(negedge clk);
    check_eq("abort_idle", 64'(arb_if.busy), 64'd0);
    tick();
    arb_if.if_pc = 32'h200;
    arb_if.if_req = 1'b1;
    arb_if.if_abort = 1'b1;
    tick();
    arb_if.if_req = 1'b0;
    arb_if.if_abort = 1'b0;
    @(negedge clk);
    check_eq("abort_no_accept", 64'(arb_if.busy), 64'd0);
    tick();
    c0 = cyc;
    arb_if.if_req = 1'b1;
    push(exp_if, 32'h200, 32'h0010_0093, c0 + 6, 1'b1);
    drain(40, 0, 0, 0);

    // Word store paused in cycles 2-3.
    c0 = cyc;
    arb_if.d_addr = 32'h500;
    arb_if.d_wdata = 32'h1122_3344;
    arb_if.d_len = 2'b11;
    arb_if.d_w_req = 1'b1;
    push(exp_wr, 32'h500, 32'h44, c0 + 1, 1'b0);
    push(exp_wr, 32'h501, 32'h33, c0 + 4, 1'b0);
    push(exp_wr, 32'h502, 32'h22, c0 + 5, 1'b0);
    push(exp_wr, 32'h503, 32'h11, c0 + 6, 1'b0);
    push(exp_d, 32'h500, 32'd0, c0 + 7, 1'b0);
    drain(40, 0, 2, 2);

    // Reset in cycle 3 of a word load: outputs clear at once, no completion follows.
    arb_if.d_addr = 32'h100;
    arb_if.d_len = 2'b11;
    arb_if.d_r_req = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    arb_if.d_r_req = 1'b0;
    #1;
    check_zero_outs();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check_eq("post_rst_idle", 64'(arb_if.busy), 64'd0);

    check_eq("left_d", 64'(exp_d.size()), 64'd0);
    check_eq("left_if", 64'(exp_if.size()), 64'd0);
    check_eq("left_wr", 64'(exp_wr.size()), 64'd0);
    check_eq("left_ra", 64'(exp_ra.size()), 64'd0);

    finished = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
